// File: rtl/tc_io_pkg.sv
// tc_io_pkg: shared constants, state type and width helper for TinyComp I/O blocks
package tc_io_pkg;
  localparam int DATA_W = 32;
  typedef enum logic {EMPTY, FULL} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/tc_rr_pick.sv
// tc_rr_pick: combinational round-robin picker, first set bit of e scanning from ptr with wrap-around
module tc_rr_pick #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  e,
  input  logic [SW-1:0] ptr,
  output logic          any,
  output logic [SW-1:0] g
);
  assign any = |e;
  always_comb begin
    g = '0;
    for (int k = N - 1; k >= 0; k--)
      if (e[(int'(ptr) + k) % N]) g = SW'((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/tc_input_arbiter.sv
// tc_input_arbiter: round-robin share of the TinyComp input port through a single-entry holding register
module tc_input_arbiter
  import tc_io_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = DATA_W,
  parameter int SRCW = clog2(NREQ)
) (
  input  logic                Ph0,
  input  logic                Reset,
  input  logic [NREQ-1:0]     ReqValid,
  input  logic [NREQ*W-1:0]   ReqData,
  input  logic [NREQ-1:0]     ReqEnable,
  output logic [NREQ-1:0]     ReqAck,
  output logic [W-1:0]        InData,
  output logic [SRCW-1:0]     InSrc,
  output logic                InRdy,
  input  logic                InStrobe,
  output logic                Underrun
);
  state_t state;
  logic [SRCW-1:0] ptr;
  logic [SRCW-1:0] g;
  logic [NREQ-1:0] e;
  logic any;
  logic load;
  assign e = ReqValid & ReqEnable & ~ReqAck;
  tc_rr_pick #(.N(NREQ), .SW(SRCW)) u_pick (.e(e), .ptr(ptr), .any(any), .g(g));
  assign load = any && (state == EMPTY || InStrobe);
  assign InRdy = state == FULL;
  always_ff @(posedge Ph0) begin
    if (Reset) begin
      state    <= EMPTY;
      ptr      <= '0;
      InData   <= '0;
      InSrc    <= '0;
      ReqAck   <= '0;
      Underrun <= 1'b0;
    end else begin
      ReqAck   <= load ? NREQ'(1) << g : '0;
      Underrun <= InStrobe && state == EMPTY;
      ptr      <= load ? (g == SRCW'(NREQ - 1) ? '0 : g + 1'b1) : ptr;
      state    <= load ? FULL : (InStrobe ? EMPTY : state);
      if (load) begin
        InData <= ReqData[g*W +: W];
        InSrc  <= g;
      end
    end
  end
endmodule

// File: tb/tb_tc_input_arbiter.sv
// tb_tc_input_arbiter: directed scenarios plus randomized traffic checked against a cycle model
module tb_tc_input_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;
  logic Ph0 = 1'b0;
  logic Reset = 1'b1;
  logic [N-1:0] ReqValid = '0;
  logic [N-1:0] ReqEnable = '1;
  logic [N-1:0] ReqAck;
  logic [N*W-1:0] ReqData = '0;
  logic [W-1:0] InData;
  logic [SW-1:0] InSrc;
  logic InRdy;
  logic InStrobe = 1'b0;
  logic Underrun;
  int tests = 0;
  int fails = 0;
  bit m_full;
  bit m_under;
  logic [W-1:0] m_data;
  int m_src, m_ptr;
  int m_ack = -1;
  int m_ack_old = -1;
  logic [W-1:0] dat [N];

  always #5 Ph0 = ~Ph0;

  tc_input_arbiter #(.NREQ(N), .W(W), .SRCW(SW)) dut (
    .Ph0(Ph0), .Reset(Reset), .ReqValid(ReqValid), .ReqData(ReqData),
    .ReqEnable(ReqEnable), .ReqAck(ReqAck), .InData(InData), .InSrc(InSrc),
    .InRdy(InRdy), .InStrobe(InStrobe), .Underrun(Underrun)
  );

  function automatic logic [N-1:0] ack_vec(input int a);
    return a < 0 ? '0 : N'(1) << a;
  endfunction

  task automatic tick(input bit rst, input bit strobe);
    int g;
    Reset = rst;
    InStrobe = strobe;
    for (int i = 0; i < N; i++) ReqData[i*W +: W] = dat[i];
    m_ack_old = m_ack;
    if (rst) begin
      m_full = 0; m_data = '0; m_src = 0; m_ptr = 0; m_ack = -1; m_under = 0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && ReqValid[(m_ptr + k) % N] && ReqEnable[(m_ptr + k) % N] && (m_ptr + k) % N != m_ack)
          g = (m_ptr + k) % N;
      m_under = !m_full && strobe;
      if (g >= 0 && (!m_full || strobe)) begin
        m_data = dat[g]; m_src = g; m_ptr = (g + 1) % N; m_full = 1; m_ack = g;
      end else begin
        m_ack = -1;
        if (strobe) m_full = 0;
      end
    end
    @(posedge Ph0);
    @(negedge Ph0);
  endtask

  task automatic test_reset();
    ReqValid = '0;
    tick(1, 0);
    tick(1, 0);
    tests++; if (InRdy !== 1'b0) begin fails++; $display("FAIL reset_inrdy got %0b want 0", InRdy); end
    tests++; if (InData !== '0) begin fails++; $display("FAIL reset_indata got %h want 0", InData); end
    tests++; if (InSrc !== '0) begin fails++; $display("FAIL reset_insrc got %0d want 0", InSrc); end
    tests++; if (ReqAck !== '0) begin fails++; $display("FAIL reset_reqack got %b want 0000", ReqAck); end
    tests++; if (Underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun got %0b want 0", Underrun); end
  endtask

  task automatic test_single();
    ReqValid = 4'b0001;
    dat[0] = 32'hDEADBEEF;
    tick(0, 0);
    tests++; if (ReqAck !== 4'b0001) begin fails++; $display("FAIL single_ack got %b want 0001", ReqAck); end
    tests++; if (InRdy !== 1'b1) begin fails++; $display("FAIL single_inrdy got %0b want 1", InRdy); end
    tests++; if (InData !== 32'hDEADBEEF) begin fails++; $display("FAIL single_indata got %h want deadbeef", InData); end
    tests++; if (InSrc !== 2'd0) begin fails++; $display("FAIL single_insrc got %0d want 0", InSrc); end
    tick(0, 0);
    tests++; if (ReqAck !== 4'b0000) begin fails++; $display("FAIL single_no_double_ack got %b want 0000", ReqAck); end
    tests++; if (InRdy !== 1'b1) begin fails++; $display("FAIL single_hold got %0b want 1", InRdy); end
    ReqValid = '0;
    tick(0, 1);
    tests++; if (InRdy !== 1'b0) begin fails++; $display("FAIL single_consume got %0b want 0", InRdy); end
    tests++; if (Underrun !== 1'b0) begin fails++; $display("FAIL single_no_underrun got %0b want 0", Underrun); end
  endtask

  task automatic test_underrun();
    tick(0, 1);
    tests++; if (Underrun !== 1'b1) begin fails++; $display("FAIL underrun_pulse got %0b want 1", Underrun); end
    tests++; if (InRdy !== 1'b0) begin fails++; $display("FAIL underrun_inrdy got %0b want 0", InRdy); end
    tick(0, 0);
    tests++; if (Underrun !== 1'b0) begin fails++; $display("FAIL underrun_one_cycle got %0b want 0", Underrun); end
    ReqValid = 4'b1111;
    for (int i = 0; i < N; i++) dat[i] = 32'h30 + i;
    tick(0, 0);
    tests++; if (InSrc !== 2'd1) begin fails++; $display("FAIL underrun_ptr_kept got src %0d want 1", InSrc); end
    tests++; if (ReqAck !== 4'b0010) begin fails++; $display("FAIL underrun_ptr_ack got %b want 0010", ReqAck); end
  endtask

  task automatic test_back_to_back();
    tick(1, 0);
    ReqValid = 4'b1111;
    for (int i = 0; i < N; i++) dat[i] = 32'h10 + i;
    tick(0, 0);
    tests++; if (InSrc !== 2'd0) begin fails++; $display("FAIL b2b_first got src %0d want 0", InSrc); end
    for (int k = 1; k <= 8; k++) begin
      tick(0, 1);
      tests++; if (InRdy !== 1'b1) begin fails++; $display("FAIL b2b_inrdy step %0d got %0b want 1", k, InRdy); end
      tests++; if (InSrc !== SW'(k % N)) begin fails++; $display("FAIL b2b_src step %0d got %0d want %0d", k, InSrc, k % N); end
      tests++; if (InData !== 32'h10 + k % N) begin fails++; $display("FAIL b2b_data step %0d got %h want %h", k, InData, 32'h10 + k % N); end
      tests++; if (ReqAck !== ack_vec(k % N)) begin fails++; $display("FAIL b2b_ack step %0d got %b want %b", k, ReqAck, ack_vec(k % N)); end
    end
  endtask

  task automatic test_wrap();
    tick(1, 0);
    ReqValid = 4'b0010;
    tick(0, 0);
    tick(0, 0);
    ReqValid = 4'b1001;
    tick(0, 1);
    tests++; if (InSrc !== 2'd3) begin fails++; $display("FAIL wrap_first got src %0d want 3", InSrc); end
    tests++; if (ReqAck !== 4'b1000) begin fails++; $display("FAIL wrap_first_ack got %b want 1000", ReqAck); end
    tick(0, 1);
    tests++; if (InSrc !== 2'd0) begin fails++; $display("FAIL wrap_second got src %0d want 0", InSrc); end
    tests++; if (ReqAck !== 4'b0001) begin fails++; $display("FAIL wrap_second_ack got %b want 0001", ReqAck); end
  endtask

  task automatic test_enable_mask();
    tick(1, 0);
    ReqEnable = 4'b1101;
    ReqValid = 4'b1111;
    for (int i = 0; i < N; i++) dat[i] = 32'h20 + i;
    tick(0, 0);
    for (int k = 0; k < 16; k++) begin
      tick(0, 1);
      tests++; if (ReqAck[1] !== 1'b0) begin fails++; $display("FAIL mask_req1 step %0d got ack %b want bit1 clear", k, ReqAck); end
      tests++; if (InSrc !== SW'(m_src)) begin fails++; $display("FAIL mask_src step %0d got %0d want %0d", k, InSrc, m_src); end
    end
    for (int k = 0; k < 4 && m_src != 2; k++) tick(0, 1);
    tests++; if (InSrc !== 2'd2 || m_src != 2) begin fails++; $display("FAIL mask_reach_src2 got %0d want 2", InSrc); end
    ReqEnable = 4'b1001;
    tick(0, 0);
    tests++; if (InRdy !== 1'b1) begin fails++; $display("FAIL mask_held_rdy got %0b want 1", InRdy); end
    tests++; if (InData !== 32'h22) begin fails++; $display("FAIL mask_held_data got %h want 22", InData); end
    for (int k = 0; k < 8; k++) begin
      tick(0, 1);
      tests++; if (ReqAck[2:1] !== 2'b00) begin fails++; $display("FAIL mask_req2 step %0d got ack %b want bits2:1 clear", k, ReqAck); end
      tests++; if (InSrc !== SW'(m_src)) begin fails++; $display("FAIL mask2_src step %0d got %0d want %0d", k, InSrc, m_src); end
    end
    ReqEnable = 4'b1111;
  endtask

  task automatic test_reset_mid();
    tick(1, 0);
    ReqValid = 4'b1111;
    for (int i = 0; i < N; i++) dat[i] = 32'h40 + i;
    tick(0, 0);
    tick(0, 1);
    tick(1, 0);
    tests++; if (InRdy !== 1'b0) begin fails++; $display("FAIL rstmid_inrdy got %0b want 0", InRdy); end
    tests++; if (InData !== '0) begin fails++; $display("FAIL rstmid_indata got %h want 0", InData); end
    tests++; if (ReqAck !== '0) begin fails++; $display("FAIL rstmid_ack got %b want 0000", ReqAck); end
    tick(0, 0);
    tests++; if (ReqAck !== 4'b0001) begin fails++; $display("FAIL rstmid_first_ack got %b want 0001", ReqAck); end
    tests++; if (InSrc !== 2'd0) begin fails++; $display("FAIL rstmid_first_src got %0d want 0", InSrc); end
  endtask

  task automatic test_random();
    bit rst;
    tick(1, 0);
    ReqValid = '0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (ReqValid[i] && m_ack_old == i) begin
          if ($urandom_range(1) == 0) ReqValid[i] = 1'b0;
          else dat[i] = $urandom;
        end else if (!ReqValid[i] && $urandom_range(2) == 0) begin
          ReqValid[i] = 1'b1;
          dat[i] = $urandom;
        end
      end
      if ($urandom_range(15) == 0) ReqEnable = N'($urandom);
      rst = $urandom_range(99) == 0;
      tick(rst, $urandom_range(2) != 0);
      tests++; if (InRdy !== m_full) begin fails++; $display("FAIL rand_inrdy cyc %0d got %0b want %0b", c, InRdy, m_full); end
      tests++; if (InData !== m_data) begin fails++; $display("FAIL rand_indata cyc %0d got %h want %h", c, InData, m_data); end
      tests++; if (InSrc !== SW'(m_src)) begin fails++; $display("FAIL rand_insrc cyc %0d got %0d want %0d", c, InSrc, m_src); end
      tests++; if (ReqAck !== ack_vec(m_ack)) begin fails++; $display("FAIL rand_ack cyc %0d got %b want %b", c, ReqAck, ack_vec(m_ack)); end
      tests++; if (Underrun !== m_under) begin fails++; $display("FAIL rand_underrun cyc %0d got %0b want %0b", c, Underrun, m_under); end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) dat[i] = '0;
    @(negedge Ph0);
    test_reset();
    test_single();
    test_underrun();
    test_back_to_back();
    test_wrap();
    test_enable_mask();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
